// File: rtl/outbox.sv
// -----------------------------------------------------------------------------
// outbox -- byte FIFO between the CPU OUTBOX instruction and an external consumer
//
// The CPU pushes the accumulator byte iR on every cycle that wO is high. The
// consumer takes the head byte oData whenever oValid and iRd are both high.
// oData is first-word-fall-through: the head byte is always presented
// combinationally from storage. When the FIFO is empty, oData is forced to
// 8'h00.
//
// Parameters:
//   DEPTH   number of 8-bit entries (power of two, >= 2), default 8
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   iR      byte to push (raw accumulator value)
//   wO      push strobe, one push per high cycle
//   iRd     consumer ready; a pop happens when oValid && iRd
//   oFull   count == DEPTH (stalls further OUTBOX instructions)
//   oEmpty  count == 0
//   oCount  number of stored entries
//   oData   head entry, 8'h00 while empty
//   oValid  oData holds a valid entry (== !oEmpty)
//   oOvf    sticky overflow flag
//
// Build option:
//   OUTBOX_OVERFLOW_FLAG_EN  when defined, oOvf sets on any push dropped
//                            because the FIFO was full, and holds until reset.
//                            When undefined, oOvf is tied to 0.
// -----------------------------------------------------------------------------
module outbox #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             iR,
  input  logic                   wO,
  input  logic                   iRd,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oCount,
  output logic [7:0]             oData,
  output logic                   oValid,
  output logic                   oOvf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Pointer wrap relies on natural binary roll-over, so DEPTH must be 2^n.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("outbox: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic pop;
  logic push;

  // Status is decoded from the registered count only, so there is no
  // combinational path from wO or iRd to any status output.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop needs a byte already stored; a byte pushed this cycle is not yet
  // visible, so push+ready into an empty FIFO only pushes.
  assign pop  = !empty && iRd;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push = wO && (!full || pop);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only ever read after being
  // written, and oData is masked to zero while empty. A write landing on the
  // edge where reset is held is harmless: count stays 0, so that byte is
  // overwritten before it can be read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= iR;
  end

`ifdef OUTBOX_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
  logic drop;

  // A push that is neither accepted nor covered by a same-cycle pop is lost.
  assign drop = wO && full && !pop;

  always_comb begin
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign oOvf = ovf_q;
`else
  assign oOvf = 1'b0;
`endif

  assign oFull  = full;
  assign oEmpty = empty;
  assign oValid = !empty;
  assign oCount = count_q;
  assign oData  = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_outbox.sv
// -----------------------------------------------------------------------------
// tb_outbox -- self-checking bench for outbox (DEPTH = 8)
//
// A queue holds the bytes the FIFO should contain. Each bench cycle compares
// all DUT outputs against the queue, then applies the cycle's inputs to the
// queue the way the FIFO should: pops remove the head, accepted pushes append.
// -----------------------------------------------------------------------------
module tb_outbox;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef OUTBOX_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       iR;
  logic             wO;
  logic             iRd;
  logic             oFull;
  logic             oEmpty;
  logic [CNT_W-1:0] oCount;
  logic [7:0]       oData;
  logic             oValid;
  logic             oOvf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  bit         model_ovf = 1'b0;

  outbox #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iR     (iR),
    .wO     (wO),
    .iRd    (iRd),
    .oFull  (oFull),
    .oEmpty (oEmpty),
    .oCount (oCount),
    .oData  (oData),
    .oValid (oValid),
    .oOvf   (oOvf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bench cycle: drive inputs after the falling edge, compare outputs
  // against the queue, then advance the queue as the coming rising edge should.
  task automatic step(input logic w, input logic [7:0] r, input logic rd);
    int         cnt;
    logic [7:0] exp_data;
    bit         do_pop;
    bit         do_push;
    @(negedge clk);
    wO  = w;
    iR  = r;
    iRd = rd;
    #1;
    cnt      = sb.size();
    exp_data = (cnt == 0) ? 8'h00 : sb[0];

    n_checks++;
    if (oCount !== CNT_W'(cnt)) begin
      n_fail++;
      $display("FAIL count: got %0d expected %0d at %0t", oCount, cnt, $time);
    end
    n_checks++;
    if (oEmpty !== (cnt == 0) || oValid !== (cnt != 0)) begin
      n_fail++;
      $display("FAIL empty_valid: got empty=%b valid=%b expected count=%0d at %0t",
               oEmpty, oValid, cnt, $time);
    end
    n_checks++;
    if (oFull !== (cnt == DEPTH)) begin
      n_fail++;
      $display("FAIL full: got %b expected %b at %0t", oFull, cnt == DEPTH, $time);
    end
    n_checks++;
    if (oData !== exp_data) begin
      n_fail++;
      $display("FAIL data: got %h expected %h at %0t", oData, exp_data, $time);
    end
    n_checks++;
    if (oOvf !== model_ovf) begin
      n_fail++;
      $display("FAIL ovf: got %b expected %b at %0t", oOvf, model_ovf, $time);
    end

    do_pop  = (cnt > 0) && rd;
    do_push = w && ((cnt < DEPTH) || do_pop);
    if (do_pop)  void'(sb.pop_front());
    if (do_push) sb.push_back(r);
    if (w && !do_push) model_ovf = OVF_EN;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wO    = 1'b0;
    iR    = 8'h00;
    iRd   = 1'b0;
    #1;
    n_checks++;
    if (oEmpty !== 1'b1 || oFull !== 1'b0 || oValid !== 1'b0 ||
        oCount !== '0 || oData !== 8'h00 || oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got empty=%b full=%b valid=%b count=%0d data=%h ovf=%b expected 1 0 0 0 00 0",
               oEmpty, oFull, oValid, oCount, oData, oOvf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h34, 1'b0);
    step(1'b1, 8'h56, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (oCount !== CNT_W'(3) || oData !== 8'h12 || oValid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_fill: got count=%0d data=%h valid=%b expected 3 12 1",
               oCount, oData, oValid);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (oEmpty !== 1'b1 || oData !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_drain: got empty=%b data=%h expected 1 00", oEmpty, oData);
    end
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 8'h7F, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (oCount !== CNT_W'(1) || oData !== 8'h7F || oValid !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_push_pop: got count=%0d data=%h valid=%b expected 1 7f 1",
               oCount, oData, oValid);
    end
    drain();
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (oFull !== 1'b1 || oCount !== CNT_W'(DEPTH) || oData !== 8'h01 || oOvf !== OVF_EN) begin
      n_fail++;
      $display("FAIL overflow: got full=%b count=%0d data=%h ovf=%b expected 1 %0d 01 %b",
               oFull, oCount, oData, oOvf, DEPTH, OVF_EN);
    end
    drain();
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (oCount !== CNT_W'(DEPTH) || oData !== 8'h02) begin
      n_fail++;
      $display("FAIL full_push_pop: got count=%0d data=%h expected %0d 02",
               oCount, oData, DEPTH);
    end
    n_checks++;
    if (sb.size() != DEPTH || sb[DEPTH-1] !== 8'hAA) begin
      n_fail++;
      $display("FAIL full_push_pop_tail: queue size %0d, expected AA last", sb.size());
    end
    drain();
  endtask

  task automatic test_wrap();
    // Roughly two pushes per three cycles and a pop every other cycle keeps
    // the FIFO partly filled while both pointers wrap several times.
    for (int i = 0; i < 40; i++)
      step((i % 3) != 2, 8'(8'h40 + i), (i % 2) == 1);
    drain();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i), 1'b0);
    @(negedge clk);
    wO = 1'b1;
    iR = 8'hEE;
    iRd = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (oEmpty !== 1'b1 || oCount !== '0 || oValid !== 1'b0 || oData !== 8'h00 || oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got empty=%b count=%0d valid=%b data=%h ovf=%b expected 1 0 0 00 0",
               oEmpty, oCount, oValid, oData, oOvf);
    end
    sb.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (oEmpty !== 1'b1 || oCount !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got empty=%b count=%0d expected 1 0", oEmpty, oCount);
    end
  endtask

  task automatic test_first_push();
    @(negedge clk);
    rst_n = 1'b1;
    wO    = 1'b1;
    iR    = 8'hC3;
    iRd   = 1'b0;
    sb.push_back(8'hC3);
    @(posedge clk);
    #1;
    n_checks++;
    if (oCount !== CNT_W'(1) || oData !== 8'hC3) begin
      n_fail++;
      $display("FAIL first_push: got count=%0d data=%h expected 1 c3", oCount, oData);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_push_pop();
    test_full_overflow();
    test_full_push_pop();
    test_wrap();
    test_mid_reset();
    test_first_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
